// File: rtl/masked_sbox_sequencer_if.sv
// Bundle of the handshake, share and component signals of masked_sbox_sequencer.
//   in_valid / in_ready             : input state handshake (master -> slave)
//   in_share1..3                    : input shares, nibble k = bits [4k+3:4k]
//   out_valid / out_ready           : result handshake (slave -> master)
//   out_share1..3                   : result shares, valid only while out_valid
//   comp_in1..3                     : registered drive into the external quadratic component
//   comp_out1..3                    : component outputs, one cycle after comp_in
// The slave modport is the sequencer's view; master is the surrounding system.
interface masked_sbox_sequencer_if #(
    parameter int unsigned NUM_NIBBLES = 16
);
    localparam int unsigned W = 4 * NUM_NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_share1;
    logic [W-1:0] in_share2;
    logic [W-1:0] in_share3;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_share1;
    logic [W-1:0] out_share2;
    logic [W-1:0] out_share3;
    logic [3:0]   comp_in1;
    logic [3:0]   comp_in2;
    logic [3:0]   comp_in3;
    logic [3:0]   comp_out1;
    logic [3:0]   comp_out2;
    logic [3:0]   comp_out3;

    modport slave (
        input  in_valid, in_share1, in_share2, in_share3, out_ready,
        input  comp_out1, comp_out2, comp_out3,
        output in_ready, out_valid, out_share1, out_share2, out_share3,
        output comp_in1, comp_in2, comp_in3
    );

    modport master (
        output in_valid, in_share1, in_share2, in_share3, out_ready,
        output comp_out1, comp_out2, comp_out3,
        input  in_ready, out_valid, out_share1, out_share2, out_share3,
        input  comp_in1, comp_in2, comp_in3
    );
endinterface

// File: rtl/masked_sbox_sequencer.sv
// Nibble-serial sequencer for the 3-share second-order masked Midori S-box layer.
// A full 3-share state is buffered, then every nibble is streamed twice through an external
// registered quadratic component (1-cycle latency). Share-wise affine maps (bit permutation
// on all shares, constant on share 1 only) are applied around each pass; shares never mix.
// Ports:
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   bus_io  : slave modport carrying in/out handshakes, shares and the component link
module masked_sbox_sequencer #(
    parameter int unsigned NUM_NIBBLES = 16,
    parameter logic [7:0]  PERM_IN     = 8'hE4,
    parameter logic [3:0]  CONST_IN    = 4'h0,
    parameter logic [7:0]  PERM_MID    = 8'hE4,
    parameter logic [3:0]  CONST_MID   = 4'h0,
    parameter logic [7:0]  PERM_OUT    = 8'hE4,
    parameter logic [3:0]  CONST_OUT   = 4'h0
) (
    input logic                    clk,
    input logic                    rst_n,
    masked_sbox_sequencer_if.slave bus_io
);
    localparam int unsigned W    = 4 * NUM_NIBBLES;
    localparam int unsigned CntW = $clog2(NUM_NIBBLES + 2);
    localparam logic [CntW-1:0] CntLast = CntW'(NUM_NIBBLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(NUM_NIBBLES);
    localparam logic [7:0] PermId = 8'hE4;

    typedef enum logic [1:0] {StIdle, StPass1, StPass2, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    share1_q, share1_d;
    logic [W-1:0]    share2_q, share2_d;
    logic [W-1:0]    share3_q, share3_d;
    logic [3:0]      comp1_q, comp1_d;
    logic [3:0]      comp2_q, comp2_d;
    logic [3:0]      comp3_q, comp3_d;

    logic       in_fire, out_fire, busy, pass_end, load_en, cap_en;
    logic [7:0] load_perm, cap_perm;
    logic [3:0] load_const, cap_const;
    logic [3:0] ld1, ld2, ld3;

    // Output bit j takes input bit p[2j+1:2j].
    function automatic logic [3:0] perm_nib(input logic [3:0] n, input logic [7:0] p);
        logic [3:0] o;
        for (int j = 0; j < 4; j++) begin
            o[j] = n[p[2*j +: 2]];
        end
        return o;
    endfunction

    assign busy     = (state_q == StPass1) || (state_q == StPass2);
    assign in_fire  = bus_io.in_valid && (state_q == StIdle);
    assign out_fire = bus_io.out_ready && (state_q == StDone);
    assign pass_end = busy && (cnt_q == CntLast);
    assign load_en  = busy && (cnt_q < CntLoad);
    // Component output for nibble k appears two steps after it was loaded.
    assign cap_en   = busy && (cnt_q >= CntW'(2));

    assign load_perm  = (state_q == StPass1) ? PERM_IN   : PermId;
    assign load_const = (state_q == StPass1) ? CONST_IN  : 4'h0;
    assign cap_perm   = (state_q == StPass1) ? PERM_MID  : PERM_OUT;
    assign cap_const  = (state_q == StPass1) ? CONST_MID : CONST_OUT;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_fire)  state_d = StPass1;
            StPass1: if (pass_end) state_d = StPass2;
            StPass2: if (pass_end) state_d = StDone;
            StDone:  if (out_fire) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; the component is driven only from registers.
    always_comb begin
        bus_io.in_ready   = (state_q == StIdle);
        bus_io.out_valid  = (state_q == StDone);
        bus_io.out_share1 = share1_q;
        bus_io.out_share2 = share2_q;
        bus_io.out_share3 = share3_q;
        bus_io.comp_in1   = comp1_q;
        bus_io.comp_in2   = comp2_q;
        bus_io.comp_in3   = comp3_q;
    end

    // Datapath next state. Load reads nibble cnt, capture writes nibble cnt-2: never the same.
    always_comb begin
        cnt_d    = cnt_q;
        share1_d = share1_q;
        share2_d = share2_q;
        share3_d = share3_q;
        comp1_d  = comp1_q;
        comp2_d  = comp2_q;
        comp3_d  = comp3_q;
        ld1      = 4'h0;
        ld2      = 4'h0;
        ld3      = 4'h0;
        for (int k = 0; k < int'(NUM_NIBBLES); k++) begin
            if (cnt_q == CntW'(k)) begin
                ld1 = share1_q[4*k +: 4];
                ld2 = share2_q[4*k +: 4];
                ld3 = share3_q[4*k +: 4];
            end
        end
        if (in_fire) begin
            share1_d = bus_io.in_share1;
            share2_d = bus_io.in_share2;
            share3_d = bus_io.in_share3;
            cnt_d    = '0;
        end else if (busy) begin
            cnt_d = pass_end ? '0 : cnt_q + CntW'(1);
            if (load_en) begin
                comp1_d = perm_nib(ld1, load_perm) ^ load_const;
                comp2_d = perm_nib(ld2, load_perm);
                comp3_d = perm_nib(ld3, load_perm);
            end
            if (cap_en) begin
                for (int k = 0; k < int'(NUM_NIBBLES); k++) begin
                    if (cnt_q == CntW'(k + 2)) begin
                        share1_d[4*k +: 4] = perm_nib(bus_io.comp_out1, cap_perm) ^ cap_const;
                        share2_d[4*k +: 4] = perm_nib(bus_io.comp_out2, cap_perm);
                        share3_d[4*k +: 4] = perm_nib(bus_io.comp_out3, cap_perm);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            share1_q <= '0;
            share2_q <= '0;
            share3_q <= '0;
            comp1_q  <= '0;
            comp2_q  <= '0;
            comp3_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            share1_q <= share1_d;
            share2_q <= share2_d;
            share3_q <= share3_d;
            comp1_q  <= comp1_d;
            comp2_q  <= comp2_d;
            comp3_q  <= comp3_d;
        end
    end
endmodule

// File: tb/tb_masked_sbox_sequencer.sv
// Self-checking bench: four sequencers with different affine maps run in lockstep on the
// same stimulus; each has an identity component model (one register per share). Expected
// results are computed from the map definitions and queued at accept time.
module tb_masked_sbox_sequencer;
    localparam int unsigned NN = 16;
    localparam int NDUT = 4;
    typedef logic [63:0] word_t;

    localparam logic [7:0] PIN  [NDUT] = '{8'hE4, 8'hE4, 8'hE4, 8'h4E};
    localparam logic [3:0] CIN  [NDUT] = '{4'h0, 4'h0, 4'h0, 4'h5};
    localparam logic [7:0] PMID [NDUT] = '{8'hE4, 8'hE4, 8'h1B, 8'hE4};
    localparam logic [3:0] CMID [NDUT] = '{4'h0, 4'h0, 4'h0, 4'h3};
    localparam logic [7:0] POUT [NDUT] = '{8'hE4, 8'hE4, 8'hE4, 8'h93};
    localparam logic [3:0] COUT [NDUT] = '{4'h0, 4'hF, 4'h0, 4'h0};

    typedef struct packed {
        logic [NDUT-1:0][2:0][63:0] e;
        int                         acc;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b1;
    logic  in_valid = 1'b0;
    logic  out_ready = 1'b1;
    word_t in_s1 = '0;
    word_t in_s2 = '0;
    word_t in_s3 = '0;

    logic [NDUT-1:0] rdy, ov;
    logic [NDUT-1:0] prev_ov = '0;
    word_t           got [NDUT][3];
    logic [3:0]      cin [NDUT][3];

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   last_acc = 0;
    int   ready_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar d = 0; d < NDUT; d++) begin : g_dut
        masked_sbox_sequencer_if #(.NUM_NIBBLES(NN)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.in_share1 = in_s1;
        assign bus.in_share2 = in_s2;
        assign bus.in_share3 = in_s3;
        assign bus.out_ready = out_ready;
        assign rdy[d]    = bus.in_ready;
        assign ov[d]     = bus.out_valid;
        assign got[d][0] = bus.out_share1;
        assign got[d][1] = bus.out_share2;
        assign got[d][2] = bus.out_share3;
        assign cin[d][0] = bus.comp_in1;
        assign cin[d][1] = bus.comp_in2;
        assign cin[d][2] = bus.comp_in3;
        always @(posedge clk) begin
            bus.comp_out1 <= bus.comp_in1;
            bus.comp_out2 <= bus.comp_in2;
            bus.comp_out3 <= bus.comp_in3;
        end
        masked_sbox_sequencer #(
            .NUM_NIBBLES(NN),
            .PERM_IN    (PIN[d]),
            .CONST_IN   (CIN[d]),
            .PERM_MID   (PMID[d]),
            .CONST_MID  (CMID[d]),
            .PERM_OUT   (POUT[d]),
            .CONST_OUT  (COUT[d])
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus_io(bus)
        );
    end

    task automatic check(input string tag, input word_t act, input word_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] pmap(input logic [3:0] n, input logic [7:0] p);
        logic [3:0] o;
        for (int j = 0; j < 4; j++) o[j] = n[p[2*j +: 2]];
        return o;
    endfunction

    // Pass 1: load map IN, identity component, capture map MID.
    // Pass 2: identity load, identity component, capture map OUT.
    function automatic logic [2:0][63:0] model(input word_t a, input word_t b, input word_t c,
                                               input int d);
        logic [2:0][63:0] x, r;
        logic [3:0]       n;
        x[0] = a;
        x[1] = b;
        x[2] = c;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < 3; s++) begin
                n = x[s][4*k +: 4];
                n = pmap(n, PIN[d]) ^ ((s == 0) ? CIN[d] : 4'h0);
                n = pmap(n, PMID[d]) ^ ((s == 0) ? CMID[d] : 4'h0);
                n = pmap(n, POUT[d]) ^ ((s == 0) ? COUT[d] : 4'h0);
                r[s][4*k +: 4] = n;
            end
        end
        return r;
    endfunction

    // Scoreboard consumer: latency on the rising out_valid, data on each handshake.
    always @(negedge clk) begin
        exp_t ex;
        if (!rst_n) begin
            prev_ov <= '0;
        end else begin
            if (ov[0] && !prev_ov[0]) begin
                if (sb.size() == 0) check("spurious_valid", word_t'(ov[0]), 64'd0);
                else check("latency", word_t'(cyc - sb[0].acc), 64'd36);
            end
            if (ov[0] && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", word_t'(ov[0]), 64'd0);
                end else begin
                    ex = sb.pop_front();
                    for (int d = 0; d < NDUT; d++) begin
                        check($sformatf("dut%0d_valid", d), word_t'(ov[d]), 64'd1);
                        for (int s = 0; s < 3; s++) begin
                            check($sformatf("dut%0d_share%0d", d, s + 1), got[d][s],
                                  ex.e[d][s]);
                        end
                    end
                end
            end
            prev_ov <= ov;
        end
    end

    task automatic reset_checks(input string pfx);
        check({pfx, "_in_ready"}, word_t'(rdy), word_t'({NDUT{1'b1}}));
        check({pfx, "_out_valid"}, word_t'(ov), 64'd0);
        for (int d = 0; d < NDUT; d++) begin
            for (int s = 0; s < 3; s++) begin
                check($sformatf("%s_comp_in_d%0d_s%0d", pfx, d, s + 1), word_t'(cin[d][s]),
                      64'd0);
                check($sformatf("%s_out_share_d%0d_s%0d", pfx, d, s + 1), got[d][s], 64'd0);
            end
        end
    endtask

    task automatic send(input word_t a, input word_t b, input word_t c);
        exp_t ex;
        int   n;
        @(negedge clk);
        in_s1 = a;
        in_s2 = b;
        in_s3 = c;
        in_valid = 1'b1;
        n = 0;
        while (!rdy[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        ready_cyc = cyc;
        if (!rdy[0]) begin
            check("send_ready_timeout", word_t'(rdy[0]), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) ex.e[d] = model(a, b, c, d);
        ex.acc = cyc;
        last_acc = cyc;
        sb.push_back(ex);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !rdy[0]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || !rdy[0]) check("drain_timeout", word_t'(sb.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    n, acc1;
        word_t stim [4][3];
        stim[0] = '{64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, 64'h0};
        stim[1] = '{64'h1111111111111111, 64'h0, 64'h0};
        stim[2] = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
        stim[3] = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_checks("por");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Pattern sweep, one state at a time.
        for (int i = 0; i < 4; i++) begin
            send(stim[i][0], stim[i][1], stim[i][2]);
            wait_idle();
        end

        // Backpressure in DONE; in_valid pulses must be ignored.
        out_ready = 1'b0;
        send(64'hA5A5_5A5A_C3C3_3C3C, 64'h0F0F_F0F0_1234_5678, 64'h8421_8421_DEAD_BEEF);
        n = 0;
        @(negedge clk);
        while (!ov[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_valid_rise", word_t'(ov[0]), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", word_t'(ov), word_t'({NDUT{1'b1}}));
            check("hold_in_ready", word_t'(rdy), 64'd0);
            if (sb.size() > 0) begin
                for (int d = 0; d < NDUT; d++) begin
                    for (int s = 0; s < 3; s++) begin
                        check($sformatf("hold_d%0d_s%0d", d, s + 1), got[d][s], sb[0].e[d][s]);
                    end
                end
            end
            if (i == 2) begin
                in_s1 = 64'hFFFF_FFFF_FFFF_FFFF;
                in_valid = 1'b1;
            end
            if (i == 6) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", word_t'(rdy), word_t'({NDUT{1'b1}}));
        check("release_out_valid", word_t'(ov), 64'd0);

        // Reset in PASS1 at cnt=5 drops the state in flight.
        send(stim[2][0], stim[2][1], stim[2][2]);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(stim[0][0], stim[0][1], stim[0][2]);
        wait_idle();

        // Back-to-back states with out_ready high.
        send(stim[3][0], stim[3][1], stim[3][2]);
        acc1 = last_acc;
        send(stim[1][0], stim[1][1], stim[1][2]);
        check("accept_to_ready", word_t'(ready_cyc - acc1), 64'd37);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
